// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with a unified memory.
// Decodes opcode in DECODE/MEM_ADR, counts retired instructions, traps unsupported opcodes.
module multi_cycle_control #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               illegal,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEM_ADR = 4'd2,  MEM_RD  = 4'd3,
      MEM_WB  = 4'd4,  MEM_WR  = 4'd5,  EXEC    = 4'd6,  R_WB    = 4'd7,
      BRANCH  = 4'd8,  JUMP    = 4'd9,  ADDI_EX = 4'd10, ADDI_WB = 4'd11,
      TRAP    = 4'd15
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       fetch_upd;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
   } ctrl_t;

   // Per-state Moore output table; fetch_upd is later qualified by mem_ready.
   function automatic ctrl_t decode_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch_upd = 1'b1; end
         DECODE:  c.alu_src_b = 2'b11;
         MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         MEM_RD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
         MEM_WB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         MEM_WR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
         EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         R_WB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         BRANCH:  begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01;
            c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
         end
         JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         ADDI_WB: c.reg_write = 1'b1;
         TRAP:    c.illegal = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   state_e             state_q, state_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic [COUNT_W-1:0] instr_count_q, instr_count_d;
   logic               retire_s;

   always_comb begin
      state_d  = state_q;
      retire_s = 1'b0;
      case (state_q)
         FETCH:   state_d = mem_ready ? DECODE : FETCH;
         DECODE:  begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDI_EX;
               default:      state_d = TRAP;
            endcase
         end
         MEM_ADR: begin
            if (opcode == OP_LW)      state_d = MEM_RD;
            else if (opcode == OP_SW) state_d = MEM_WR;
            else                      state_d = TRAP;
         end
         MEM_RD:  state_d = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:  begin state_d = FETCH; retire_s = 1'b1; end
         MEM_WR:  begin
            if (mem_ready) begin
               state_d  = FETCH;
               retire_s = 1'b1;
            end else begin
               state_d  = MEM_WR;
            end
         end
         EXEC:    state_d = R_WB;
         R_WB:    begin state_d = FETCH; retire_s = 1'b1; end
         BRANCH:  begin state_d = FETCH; retire_s = 1'b1; end
         JUMP:    begin state_d = FETCH; retire_s = 1'b1; end
         ADDI_EX: state_d = ADDI_WB;
         ADDI_WB: begin state_d = FETCH; retire_s = 1'b1; end
         TRAP:    state_d = TRAP;
         default: state_d = TRAP;
      endcase
      ctrl_d        = decode_ctrl(state_d);
      instr_count_d = retire_s ? instr_count_q + COUNT_W'(1) : instr_count_q;
   end

   // Output table is registered alongside the state so it always matches state_q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         ctrl_q        <= decode_ctrl(FETCH);
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         instr_count_q <= instr_count_d;
      end
   end

   assign pc_write      = rst_n & (ctrl_q.pc_write | (ctrl_q.fetch_upd & mem_ready));
   assign ir_write      = rst_n & ctrl_q.fetch_upd & mem_ready;
   assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
   assign mem_read      = rst_n & ctrl_q.mem_read;
   assign mem_write     = rst_n & ctrl_q.mem_write;
   assign reg_write     = rst_n & ctrl_q.reg_write;
   assign illegal       = rst_n & ctrl_q.illegal;
   assign i_or_d        = ctrl_q.i_or_d;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_op        = ctrl_q.alu_op;
   assign pc_source     = ctrl_q.pc_source;
   assign state         = state_q;
   assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: expected per-cycle state/outputs/count are
// queued as each cycle is driven and compared against what the DUT shows at the falling edge.
module tb_multi_cycle_control;

   localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,  S_MA = 4'd2,  S_MR = 4'd3,
                          S_MWB = 4'd4, S_MWR = 4'd5, S_EX = 4'd6, S_RWB = 4'd7,
                          S_BR = 4'd8, S_J = 4'd9, S_AEX = 4'd10, S_AWB = 4'd11,
                          S_TRAP = 4'd15;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                          OP_BAD = 6'b111111;

   logic        clk = 1'b0;
   logic        rst_n, zero, mem_ready;
   logic [5:0]  opcode;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic [31:0] instr_count;

   logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
   logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal;
   logic [1:0]  w_alu_src_b, w_alu_op, w_pc_source;
   logic [3:0]  w_state;
   logic [3:0]  w_instr_count;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic [52:0] exp_q[$];
   logic [52:0] act_q[$];

   multi_cycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   multi_cycle_control #(.COUNT_W(4)) dut_w4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .i_or_d(w_i_or_d),
      .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
      .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write),
      .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
      .pc_source(w_pc_source), .illegal(w_illegal), .state(w_state),
      .instr_count(w_instr_count)
   );

   always #5 clk = ~clk;

   // Expected outputs per state straight from the state output table.
   function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic rn);
      logic pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, a, ill;
      logic [1:0] b, op, ps;
      {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, a, ill} = 11'd0;
      b = 2'b00; op = 2'b00; ps = 2'b00;
      case (st)
         S_F:    begin mrd = 1'b1; b = 2'b01; irw = mr; pw = mr; end
         S_D:    b = 2'b11;
         S_MA:   begin a = 1'b1; b = 2'b10; end
         S_MR:   begin mrd = 1'b1; iod = 1'b1; end
         S_MWB:  begin rw = 1'b1; m2r = 1'b1; end
         S_MWR:  begin mwr = 1'b1; iod = 1'b1; end
         S_EX:   begin a = 1'b1; op = 2'b10; end
         S_RWB:  begin rw = 1'b1; rd = 1'b1; end
         S_BR:   begin a = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
         S_J:    begin pw = 1'b1; ps = 2'b10; end
         S_AEX:  begin a = 1'b1; b = 2'b10; end
         S_AWB:  rw = 1'b1;
         S_TRAP: ill = 1'b1;
         default: ill = 1'b0;
      endcase
      if (!rn) {pw, pwc, mrd, mwr, irw, rw, ill} = 7'd0;
      return {pw, pwc, iod, mrd, mwr, irw, rd, m2r, rw, a, b, op, ps, ill};
   endfunction

   function automatic logic [52:0] dut_vec();
      return {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
              illegal, instr_count};
   endfunction

   task automatic drive(input logic rn, input logic mr, input logic [5:0] op,
                        input logic [3:0] st_exp);
      rst_n = rn; mem_ready = mr; opcode = op; zero = 1'($urandom_range(0, 1));
      exp_q.push_back({st_exp, exp_ctrl(st_exp, mr, rn), exp_cnt});
      @(negedge clk);
      act_q.push_back(dut_vec());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [52:0] e, a;
      drive(1'b0, 1'b1, OP_BAD, S_F);
      drive(1'b1, 1'b0, OP_R, S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL reset: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_beq_j();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_BEQ, S_F);
      drive(1'b1, 1'b1, OP_BEQ, S_D);
      drive(1'b1, 1'b1, OP_R,   S_BR);
      exp_cnt++;
      drive(1'b1, 1'b1, OP_J,   S_F);
      drive(1'b1, 1'b1, OP_J,   S_D);
      drive(1'b1, 1'b0, OP_BAD, S_J);
      exp_cnt++;
      drive(1'b1, 1'b0, OP_R,   S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL beq_j: got %h expected %h", a, e); end
      end
      checks++;
      if (instr_count !== 32'd2) begin
         failures++; $display("FAIL beq_j_count: got %0d expected 2", instr_count);
      end
   endtask

   task automatic test_rtype();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_R,   S_F);
      drive(1'b1, 1'b1, OP_R,   S_D);
      drive(1'b1, 1'b1, OP_BAD, S_EX);
      drive(1'b1, 1'b1, OP_LW,  S_RWB);
      exp_cnt++;
      drive(1'b1, 1'b0, OP_R,   S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL rtype: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_lw_wait();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_LW, S_F);
      drive(1'b1, 1'b1, OP_LW, S_D);
      drive(1'b1, 1'b0, OP_LW, S_MA);
      drive(1'b1, 1'b0, OP_SW, S_MR);
      drive(1'b1, 1'b0, OP_R,  S_MR);
      drive(1'b1, 1'b1, OP_J,  S_MR);
      drive(1'b1, 1'b0, OP_R,  S_MWB);
      exp_cnt++;
      drive(1'b1, 1'b0, OP_R,  S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL lw_wait: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_sw_addi();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_SW,   S_F);
      drive(1'b1, 1'b1, OP_SW,   S_D);
      drive(1'b1, 1'b1, OP_SW,   S_MA);
      drive(1'b1, 1'b0, OP_LW,   S_MWR);
      drive(1'b1, 1'b1, OP_LW,   S_MWR);
      exp_cnt++;
      drive(1'b1, 1'b1, OP_ADDI, S_F);
      drive(1'b1, 1'b1, OP_ADDI, S_D);
      drive(1'b1, 1'b1, OP_BEQ,  S_AEX);
      drive(1'b1, 1'b1, OP_BAD,  S_AWB);
      exp_cnt++;
      drive(1'b1, 1'b0, OP_R,    S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL sw_addi: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_reset_in_wr();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_SW, S_F);
      drive(1'b1, 1'b1, OP_SW, S_D);
      drive(1'b1, 1'b1, OP_SW, S_MA);
      drive(1'b1, 1'b0, OP_SW, S_MWR);
      drive(1'b0, 1'b0, OP_SW, S_MWR);
      exp_cnt = 32'd0;
      drive(1'b1, 1'b0, OP_SW, S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL reset_in_wr: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_trap();
      logic [52:0] e, a;
      drive(1'b1, 1'b1, OP_BAD, S_F);
      drive(1'b1, 1'b1, OP_BAD, S_D);
      for (int i = 0; i < 12; i++)
         drive(1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), S_TRAP);
      drive(1'b0, 1'b1, OP_R, S_TRAP);
      exp_cnt = 32'd0;
      drive(1'b1, 1'b0, OP_R, S_F);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL trap: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_back_to_back_wrap();
      logic [52:0] e, a;
      logic [3:0]  w_exp;
      for (int k = 0; k < 17; k++) begin
         w_exp = exp_cnt[3:0];
         checks++;
         if (w_instr_count !== w_exp) begin
            failures++;
            $display("FAIL wrap_count jump %0d: got %0d expected %0d", k, w_instr_count, w_exp);
         end
         if (k < 16) begin
            drive(1'b1, 1'b1, OP_J, S_F);
            drive(1'b1, 1'b1, OP_J, S_D);
            drive(1'b1, 1'b1, OP_J, S_J);
            exp_cnt++;
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
         if (a !== e) begin failures++; $display("FAIL back_to_back: got %h expected %h", a, e); end
      end
      checks++;
      if (w_instr_count !== 4'd0 || instr_count !== 32'd16) begin
         failures++;
         $display("FAIL wrap_final: got w4=%0d w32=%0d expected 0 and 16", w_instr_count, instr_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_R; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_beq_j();
      test_rtype();
      test_lw_wait();
      test_sw_addi();
      test_reset_in_wr();
      test_trap();
      test_back_to_back_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset, named as follows:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.

REQ-002 Parameter `COUNT_W`, default 32: width of the retired-instruction counter.

REQ-003 The block SHALL have these inputs:
- `opcode`  in  6  instruction[31:26] from the external instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  unified memory has completed the current read or write.

REQ-004 The block SHALL have these outputs:
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by `zero` (the datapath ANDs it).
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU input A: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU input B: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal`  out  1  unsupported opcode trapped.
- `state`  out  4  current state encoding (debug).
- `instr_count`  out  `COUNT_W`  count of retired instructions.

Function
REQ-005 The block SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=15; codes 12–14 SHALL go to TRAP on the next edge.

REQ-006 Any output not listed for a state SHALL be 0 in that state.

REQ-007 FETCH outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00; `ir_write` and `pc_write` SHALL be 1 only when `mem_ready`=1. FETCH SHALL hold while `mem_ready`=0 and go to DECODE when `mem_ready`=1.

REQ-008 DECODE outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. DECODE SHALL branch on `opcode`:
- 100011 (lw) or 101011 (sw) → MEM_ADR
- 000000 (R-type) → EXEC
- 000100 (beq) → BRANCH
- 000010 (j) → JUMP
- 001000 (addi) → ADDI_EX
- any other opcode → TRAP

REQ-009 MEM_ADR outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state SHALL be MEM_RD for lw and MEM_WR for sw.

REQ-010 MEM_RD outputs: `mem_read`=1, `i_or_d`=1. MEM_RD SHALL hold until `mem_ready`=1, then go to MEM_WB.

REQ-011 MEM_WB outputs: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state SHALL be FETCH.

REQ-012 MEM_WR outputs: `mem_write`=1, `i_or_d`=1. MEM_WR SHALL hold until `mem_ready`=1, then go to FETCH.

REQ-013 EXEC outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state SHALL be R_WB.

REQ-014 R_WB outputs: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state SHALL be FETCH.

REQ-015 BRANCH outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Next state SHALL be FETCH.

REQ-016 JUMP outputs: `pc_write`=1, `pc_source`=10. Next state SHALL be FETCH.

REQ-017 ADDI_EX outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state SHALL be ADDI_WB.

REQ-018 ADDI_WB outputs: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state SHALL be FETCH.

REQ-019 TRAP outputs: `illegal`=1 and all strobes 0. TRAP SHALL be left only by reset.

REQ-020 `opcode` SHALL be sampled only in DECODE and MEM_ADR; changes in other states SHALL have no effect.

REQ-021 `instr_count` SHALL increment by 1 on the edge leaving each of MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, and on the edge leaving MEM_WR with `mem_ready`=1; it SHALL wrap from all-ones to 0.

REQ-022 Instruction latencies with zero memory wait SHALL be: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle SHALL add exactly 1 cycle.

REQ-023 `mem_read` and `mem_write` SHALL never both be 1 in the same cycle.

Reset
REQ-024 When `rst_n`=0 at a rising edge of `clk`, `state` SHALL become FETCH and `instr_count` SHALL become 0, from any state including mid-wait and TRAP.

REQ-025 While `rst_n`=0, all strobes (`pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`) SHALL be forced to 0 combinationally, and `illegal` SHALL be 0.

REQ-026 On the first cycle after `rst_n` returns to 1, the block SHALL begin a FETCH.

Verification
REQ-027 R-type, `mem_ready`=1 constantly, `opcode`=000000: states 0→1→6→7→0; `reg_write`=1 and `reg_dst`=1 in cycle 4 only; `instr_count` 0→1.

REQ-028 lw with `mem_ready` low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0; `mem_to_reg`=1 only in the state-4 cycle; total 7 cycles.

REQ-029 beq then j: BRANCH shows `pc_write_cond`=1, `alu_op`=01, `pc_source`=01; JUMP shows `pc_write`=1, `pc_source`=10; `instr_count`=2 afterwards.

REQ-030 `opcode`=111111 in DECODE: state goes to 15 with `illegal`=1 and holds for ≥10 cycles regardless of inputs; `rst_n`=0 for one edge → state 0 and `illegal`=0.

REQ-031 Reset asserted in MEM_WR while `mem_ready`=0: `mem_write`=0 in the same cycle; state=0 and `instr_count`=0 after the edge.

REQ-032 With `COUNT_W`=4, 16 back-to-back j instructions: `instr_count` wraps 15→0.
